// File: rtl/bcd_share_arb_if.sv
// Handshake and converter bus between the calendar requesters, the shared
// binary-to-BCD converter and the bcd_share_arb sequencer.
interface bcd_share_arb_if #(
  parameter int NUM_REQ = 6,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] bin_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic [7:0]           conv_bin;
  logic [3:0]           conv_hundreds;
  logic [3:0]           conv_tens;
  logic [3:0]           conv_ones;
  logic [11:0]          bcd_out;
  logic [ID_W-1:0]      bcd_id;
  logic                 bcd_valid;

  // master: requesters plus the external converter; slave: the arbiter
  modport master (
    output req, bin_data, conv_hundreds, conv_tens, conv_ones,
    input  ack, busy, conv_bin, bcd_out, bcd_id, bcd_valid
  );

  modport slave (
    input  req, bin_data, conv_hundreds, conv_tens, conv_ones,
    output ack, busy, conv_bin, bcd_out, bcd_id, bcd_valid
  );
endinterface

// File: rtl/bcd_share_arb.sv
// Round-robin sequencer sharing one combinational binary-to-BCD converter
// among calendar field requesters; one conversion every three cycles.
//
// state | meaning
// IDLE  | waiting for any req; grants winner and registers its operand
// CONV  | converter settling on conv_bin; result and owner captured
// DONE  | bcd_valid and ack[sel] pulse for this single cycle
module bcd_share_arb #(
  parameter int NUM_REQ = 6,
  parameter int ID_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_share_arb_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      sel_q, sel_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [7:0]           conv_bin_q, conv_bin_d;
  logic [11:0]          bcd_out_q, bcd_out_d;
  logic [ID_W-1:0]      bcd_id_q, bcd_id_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [ID_W-1:0]      win;
  logic                 found;

  // search starts just after the last served requester and wraps
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req[(int'(last_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    conv_bin_d  = conv_bin_q;
    bcd_out_d   = bcd_out_q;
    bcd_id_d    = bcd_id_q;
    bcd_valid_d = 1'b0;
    ack_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = CONV;
          sel_d      = win;
          conv_bin_d = bus.bin_data[int'(win)*8 +: 8];
        end
      end
      CONV: begin
        bcd_out_d   = {bus.conv_hundreds, bus.conv_tens, bus.conv_ones};
        bcd_id_d    = sel_q;
        last_d      = sel_q;
        bcd_valid_d = 1'b1;
        ack_d       = NUM_REQ'(1) << sel_q;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= LAST_RST;
      conv_bin_q  <= '0;
      bcd_out_q   <= '0;
      bcd_id_q    <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      conv_bin_q  <= conv_bin_d;
      bcd_out_q   <= bcd_out_d;
      bcd_id_q    <= bcd_id_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
    end
  end

  assign bus.conv_bin  = conv_bin_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.bcd_id    = bcd_id_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.ack       = ack_q;

endmodule
